// File: rtl/synchronizer.sv
// Multi-flop synchronizer for one async level bit, with rise/fall tick decode.
// Latency SYNC_STAGES clk edges from first capturing edge; ticks align with sync_out; no backpressure.
module synchronizer #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise_edge_tick,
  output logic fall_edge_tick
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("synchronizer: SYNC_STAGES must be >= 2");
  end

  // Chain must stay a plain flop cascade: tools keep it together and never retime it.
  (* ASYNC_REG = "TRUE", DONT_RETIME = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [SYNC_STAGES-1:0] stage;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], async_in};
      prev  <= stage[SYNC_STAGES-1];
    end
  end

  assign sync_out       = stage[SYNC_STAGES-1];
  assign rise_edge_tick = sync_out & ~prev;
  assign fall_edge_tick = ~sync_out & prev;

endmodule

// File: tb/tb_synchronizer.sv
// Directed bench: default instance (2 stages, reset 0) and a 3-stage instance resetting to 1.
module tb_synchronizer;

  logic clk = 1'b0;
  logic reset;
  logic async_a, async_b;
  logic sync_a, rise_a, fall_a;
  logic sync_b, rise_b, fall_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  synchronizer dut_a (
    .clk(clk), .reset(reset), .async_in(async_a),
    .sync_out(sync_a), .rise_edge_tick(rise_a), .fall_edge_tick(fall_a)
  );

  synchronizer #(.SYNC_STAGES(3), .RESET_VAL(1'b1)) dut_b (
    .clk(clk), .reset(reset), .async_in(async_b),
    .sync_out(sync_b), .rise_edge_tick(rise_b), .fall_edge_tick(fall_b)
  );

  // Outputs are sampled and inputs driven at the falling edge, away from the active edge.
  task automatic test_reset();
    logic [2:0] got;
    reset   = 1'b1;
    async_a = 1'b0;
    async_b = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      got = {sync_a, rise_a, fall_a};
      checks++;
      if (got !== 3'b000) begin
        errors++;
        $display("FAIL reset_a cycle=%0d got={sync,rise,fall}=%b exp=000", n, got);
      end
      got = {sync_b, rise_b, fall_b};
      checks++;
      if (got !== 3'b100) begin
        errors++;
        $display("FAIL reset_b cycle=%0d got={sync,rise,fall}=%b exp=100", n, got);
      end
    end
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      got = {sync_a, rise_a, fall_a};
      checks++;
      if (got !== 3'b000) begin
        errors++;
        $display("FAIL reset_release_a cycle=%0d got=%b exp=000", n, got);
      end
      got = {sync_b, rise_b, fall_b};
      checks++;
      if (got !== 3'b100) begin
        errors++;
        $display("FAIL reset_release_b cycle=%0d got=%b exp=100", n, got);
      end
    end
  endtask

  task automatic test_rise_edge();
    logic [2:0] got, exp;
    async_a = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      exp = {(n >= 2) ? 1'b1 : 1'b0, (n == 2) ? 1'b1 : 1'b0, 1'b0};
      got = {sync_a, rise_a, fall_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rise_edge cycle=%0d got={sync,rise,fall}=%b exp=%b", n, got, exp);
      end
    end
  endtask

  task automatic test_fall_edge();
    logic [2:0] got, exp;
    async_a = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      exp = {(n < 2) ? 1'b1 : 1'b0, 1'b0, (n == 2) ? 1'b1 : 1'b0};
      got = {sync_a, rise_a, fall_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fall_edge cycle=%0d got={sync,rise,fall}=%b exp=%b", n, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] got, exp;
    logic       lvl;
    int         rises = 0, falls = 0, last = 0;
    lvl = 1'b0;
    for (int t = 0; t < 4; t++) begin
      lvl     = ~lvl;
      async_a = lvl;
      for (int n = 1; n <= 3; n++) begin
        @(negedge clk);
        exp = {(n >= 2) ? lvl : ~lvl, (n == 2) && lvl, (n == 2) && !lvl};
        got = {sync_a, rise_a, fall_a};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL back_to_back t=%0d cycle=%0d got=%b exp=%b", t, n, got, exp);
        end
        if (rise_a === 1'b1) begin
          checks++;
          if (last == 1) begin
            errors++;
            $display("FAIL alternation got=rise-after-rise exp=rise-after-fall");
          end
          rises++;
          last = 1;
        end
        if (fall_a === 1'b1) begin
          checks++;
          if (last != 1) begin
            errors++;
            $display("FAIL alternation got=fall-without-prior-rise exp=fall-after-rise");
          end
          falls++;
          last = 2;
        end
      end
    end
    checks++;
    if (rises != 2 || falls != 2) begin
      errors++;
      $display("FAIL toggle_counts got rises=%0d falls=%0d exp rises=2 falls=2", rises, falls);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] got, exp;
    async_a = 1'b1;
    @(negedge clk);
    got = {sync_a, rise_a, fall_a};
    checks++;
    if (got !== 3'b000) begin
      errors++;
      $display("FAIL mid_inflight got=%b exp=000", got);
    end
    reset = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      got = {sync_a, rise_a, fall_a};
      checks++;
      if (got !== 3'b000) begin
        errors++;
        $display("FAIL mid_reset_a cycle=%0d got=%b exp=000", n, got);
      end
      got = {sync_b, rise_b, fall_b};
      checks++;
      if (got !== 3'b100) begin
        errors++;
        $display("FAIL mid_reset_b cycle=%0d got=%b exp=100", n, got);
      end
    end
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      exp = {(n >= 2) ? 1'b1 : 1'b0, (n == 2) ? 1'b1 : 1'b0, 1'b0};
      got = {sync_a, rise_a, fall_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_release cycle=%0d got=%b exp=%b", n, got, exp);
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [2:0] got, exp;
    async_b = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      exp = {(n < 3) ? 1'b1 : 1'b0, 1'b0, (n == 3) ? 1'b1 : 1'b0};
      got = {sync_b, rise_b, fall_b};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sweep_3stage cycle=%0d got={sync,rise,fall}=%b exp=%b", n, got, exp);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    async_a = 1'b0;
    async_b = 1'b1;
    test_reset();
    test_rise_edge();
    test_fall_edge();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
